// File: rtl/car_lights_pkg.sv
// ============================================================================
// Module      : car_lights_pkg
// Description : Shared state enum, lamp-vector type and lamp patterns for the
//               tail-light sequencer. Optional macro: HAZARD_EN adds HAZ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package car_lights_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L3   = 3'd3,
      R1   = 3'd4,
      R2   = 3'd5,
      R3   = 3'd6
`ifdef HAZARD_EN
      ,
      HAZ  = 3'd7
`endif
   } state_t;

   // Lamp vector bit order is {la,lb,lc,ra,rb,rc}
   typedef logic [5:0] lamps_t;

   localparam lamps_t LAMPS_OFF = 6'b000000;
   localparam lamps_t L1_PAT    = 6'b100000;
   localparam lamps_t L2_PAT    = 6'b110000;
   localparam lamps_t L3_PAT    = 6'b111000;
   localparam lamps_t R1_PAT    = 6'b000100;
   localparam lamps_t R2_PAT    = 6'b000110;
   localparam lamps_t R3_PAT    = 6'b000111;
   localparam lamps_t HAZ_PAT   = 6'b111111;

endpackage

`default_nettype wire

// File: rtl/tail_lamp_decode.sv
// ============================================================================
// Module      : tail_lamp_decode
// Description : Combinational decode of sequencer state to the 6-bit lamp
//               vector. Optional macro: HAZARD_EN decodes HAZ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tail_lamp_decode
   import car_lights_pkg::*;
(
   input  logic [2:0] state,
   output logic [5:0] lamps
);

   always_comb begin
      lamps = LAMPS_OFF;
      case (state)
         IDLE:    lamps = LAMPS_OFF;
         L1:      lamps = L1_PAT;
         L2:      lamps = L2_PAT;
         L3:      lamps = L3_PAT;
         R1:      lamps = R1_PAT;
         R2:      lamps = R2_PAT;
         R3:      lamps = R3_PAT;
`ifdef HAZARD_EN
         HAZ:     lamps = HAZ_PAT;
`endif
         default: lamps = LAMPS_OFF;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/car_tail_lights_sequencer.sv
// ============================================================================
// Module      : car_tail_lights_sequencer
// Description : Moore FSM sequencing three tail lamps per side on a turn
//               request. Optional macro: HAZARD_EN (both requests -> hazard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module car_tail_lights_sequencer
   import car_lights_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic left,
   input  logic right,
   output logic la,
   output logic lb,
   output logic lc,
   output logic ra,
   output logic rb,
   output logic rc
);

   state_t       r_state;
   logic [5:0]   w_lamps;

   // Requests are only looked at in IDLE; a started sequence always runs out
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (left && !right)
                  r_state <= L1;
               else if (right && !left)
                  r_state <= R1;
`ifdef HAZARD_EN
               else if (left && right)
                  r_state <= HAZ;
`endif
               else
                  r_state <= IDLE;
            end
            L1:      r_state <= L2;
            L2:      r_state <= L3;
            L3:      r_state <= IDLE;
            R1:      r_state <= R2;
            R2:      r_state <= R3;
            R3:      r_state <= IDLE;
`ifdef HAZARD_EN
            HAZ:     r_state <= IDLE;
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   tail_lamp_decode u_decode (
      .state (r_state),
      .lamps (w_lamps)
   );

   assign {la, lb, lc, ra, rb, rc} = w_lamps;

endmodule

`default_nettype wire

// File: tb/tb_car_tail_lights_sequencer.sv
// ============================================================================
// Module      : tb_car_tail_lights_sequencer
// Description : Vector table plus queue-based reference model for the
//               tail-light sequencer. Optional macro: HAZARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_car_tail_lights_sequencer;

   typedef struct {
      logic       rst;
      logic       l;
      logic       r;
      logic [5:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic left = 1'b0;
   logic right = 1'b0;
   logic la, lb, lc, ra, rb, rc;

   int tests = 0;
   int fails = 0;

   vec_t       vecs[$];
   logic [5:0] model_q[$];

   always #5 clk = ~clk;

   car_tail_lights_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .left  (left),
      .right (right),
      .la    (la),
      .lb    (lb),
      .lc    (lc),
      .ra    (ra),
      .rb    (rb),
      .rc    (rc)
   );

   task automatic add(input logic r_i, input logic l_i, input logic rt_i, input logic [5:0] e);
      vec_t v;
      v.rst = r_i; v.l = l_i; v.r = rt_i; v.exp = e;
      vecs.push_back(v);
   endtask

   // Drive inputs mid-cycle, then sample one unit after the rising edge
   task automatic step(input string name, input int idx, input logic r_i, input logic l_i,
                       input logic rt_i, input logic [5:0] e);
      logic [5:0] got;
      @(negedge clk);
      reset = r_i; left = l_i; right = rt_i;
      @(posedge clk);
      #1;
      got = {la, lb, lc, ra, rb, rc};
      tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL %s #%0d: lamps got %06b expected %06b (reset=%0b left=%0b right=%0b)",
                  name, idx, got, e, r_i, l_i, rt_i);
      end
   endtask

   // Reference: a queue of lamp patterns still owed; an empty queue means idle
   function automatic logic [5:0] model_step(input logic r_i, input logic l_i, input logic rt_i);
      logic [5:0] o;
      if (r_i) begin
         model_q.delete();
         return 6'b000000;
      end
      if (model_q.size() != 0) begin
         o = model_q.pop_front();
         return o;
      end
      if (l_i && !rt_i) begin
         model_q.push_back(6'b110000);
         model_q.push_back(6'b111000);
         model_q.push_back(6'b000000);
         return 6'b100000;
      end
      if (rt_i && !l_i) begin
         model_q.push_back(6'b000110);
         model_q.push_back(6'b000111);
         model_q.push_back(6'b000000);
         return 6'b000100;
      end
`ifdef HAZARD_EN
      if (l_i && rt_i) begin
         model_q.push_back(6'b000000);
         return 6'b111111;
      end
`endif
      return 6'b000000;
   endfunction

   initial begin
      // Reset overrides a held request, then quiet idle
      add(1, 1, 0, 6'b000000);
      add(1, 1, 0, 6'b000000);
      add(0, 0, 0, 6'b000000);
      // Left held: sequence repeats with a mandatory off cycle
      add(0, 1, 0, 6'b100000);
      add(0, 1, 0, 6'b110000);
      add(0, 1, 0, 6'b111000);
      add(0, 1, 0, 6'b000000);
      add(0, 1, 0, 6'b100000);
      add(0, 1, 0, 6'b110000);
      add(0, 1, 0, 6'b111000);
      add(0, 1, 0, 6'b000000);
      // Right single-cycle pulse completes the whole sequence
      add(0, 0, 1, 6'b000100);
      add(0, 0, 0, 6'b000110);
      add(0, 0, 0, 6'b000111);
      add(0, 0, 0, 6'b000000);
      add(0, 0, 0, 6'b000000);
      // Opposite side ignored until idle
      add(0, 1, 0, 6'b100000);
      add(0, 0, 1, 6'b110000);
      add(0, 0, 1, 6'b111000);
      add(0, 0, 1, 6'b000000);
      add(0, 0, 1, 6'b000100);
      add(0, 0, 0, 6'b000110);
      add(0, 0, 0, 6'b000111);
      add(0, 0, 0, 6'b000000);
      // Both requests in idle
`ifdef HAZARD_EN
      add(0, 1, 1, 6'b111111);
      add(0, 1, 1, 6'b000000);
      add(0, 1, 1, 6'b111111);
`else
      add(0, 1, 1, 6'b000000);
      add(0, 1, 1, 6'b000000);
      add(0, 1, 1, 6'b000000);
`endif
      add(0, 0, 0, 6'b000000);
      // Reset in L2 aborts, then a right request starts R1
      add(0, 1, 0, 6'b100000);
      add(0, 0, 0, 6'b110000);
      add(1, 0, 0, 6'b000000);
      add(0, 0, 1, 6'b000100);
      add(0, 0, 0, 6'b000110);
      add(0, 0, 0, 6'b000111);
      add(0, 0, 0, 6'b000000);
      // Left and both requests during a right sequence are ignored
      add(0, 0, 1, 6'b000100);
      add(0, 1, 0, 6'b000110);
      add(0, 1, 1, 6'b000111);
      add(0, 0, 0, 6'b000000);
      // Both requests during a left sequence are ignored
      add(0, 1, 0, 6'b100000);
      add(0, 1, 1, 6'b110000);
      add(0, 1, 1, 6'b111000);
      add(0, 0, 0, 6'b000000);

      foreach (vecs[i])
         step("vector", i, vecs[i].rst, vecs[i].l, vecs[i].r, vecs[i].exp);

      // Randomized run against the reference model, starting from reset
      model_q.delete();
      for (int k = 0; k < 400; k++) begin
         logic       r_i, l_i, rt_i;
         logic [5:0] e;
         r_i  = (k == 0) || ($urandom_range(0, 24) == 0);
         l_i  = $urandom_range(0, 1) == 1;
         rt_i = $urandom_range(0, 1) == 1;
         e    = model_step(r_i, l_i, rt_i);
         step("random", k, r_i, l_i, rt_i, e);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
